seq_detect_param: RTL and testbench

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_pkg.sv | 13 +
 rtl/seq_detect_sat_cnt.sv | 34 +++
 rtl/seq_detect_param.sv | 104 ++++++++++
 tb/tb_seq_detect_param.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared FSM state type and pattern-width limits for the sequence detector
package seq_detect_pkg;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2
    } seq_state_e;

endpackage

// File: rtl/seq_detect_sat_cnt.sv
// rtl/seq_detect_sat_cnt.sv - saturating up-counter with synchronous clear (clear beats increment)
module seq_detect_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - loadable-pattern serial sequence detector; SEQ_DETECT_COUNT_EN builds the match counter
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int              PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = 4'b1011,
    parameter int              CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             x_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             count_clr,
    output logic             detect,
    output logic [PAT_W-1:0] pattern,
    output logic             armed,
    output logic [CNT_W-1:0] match_count
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]  history_q, history_d;
    logic [PAT_W-1:0]  pattern_q, pattern_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    seq_state_e        state_q, state_d;
    logic              detect_q, detect_d;
    logic              match;

    always_comb begin
        history_d = history_q;
        pattern_d = pattern_q;
        fill_d    = fill_q;
        match     = 1'b0;
        if (pat_load) begin
            pattern_d = pat_in;
            history_d = '0;
            fill_d    = '0;
        end else if (x_valid) begin
            // Only PAT_W-1 stored bits plus the live bit take part in the compare.
            match = ({history_q[PAT_W-2:0], x} == pattern_q) &&
                    (fill_q >= FILL_W'(PAT_W - 1));
            if (match && !overlap) begin
                history_d = '0;
                fill_d    = '0;
            end else begin
                history_d = {history_q[PAT_W-2:0], x};
                if (fill_q != FILL_W'(PAT_W)) begin
                    fill_d = fill_q + 1'b1;
                end
            end
        end
        detect_d = match;

        state_d = FILLING;
        if (fill_d == '0) begin
            state_d = EMPTY;
        end else if (fill_d == FILL_W'(PAT_W)) begin
            state_d = ARMED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            history_q <= '0;
            pattern_q <= PAT_RST;
            fill_q    <= '0;
            state_q   <= EMPTY;
            detect_q  <= 1'b0;
        end else begin
            history_q <= history_d;
            pattern_q <= pattern_d;
            fill_q    <= fill_d;
            state_q   <= state_d;
            detect_q  <= detect_d;
        end
    end

    assign detect  = detect_q;
    assign pattern = pattern_q;
    assign armed   = (state_q == ARMED);

    logic unused_hist_msb;
    assign unused_hist_msb = history_q[PAT_W-1];

`ifdef SEQ_DETECT_COUNT_EN
    seq_detect_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_sat_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (count_clr),
        .inc   (match),
        .count (match_count)
    );
`else
    logic unused_count_clr;
    assign unused_count_clr = count_clr;
    assign match_count      = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - directed self-checking bench for seq_detect_param
module tb_seq_detect_param;

    localparam int PAT_W = 4;
    localparam int CNT_W = 2;
`ifdef SEQ_DETECT_COUNT_EN
    localparam int CEN = 1;
`else
    localparam int CEN = 0;
`endif

    logic             clk;
    logic             rst;
    logic             x;
    logic             x_valid;
    logic             overlap;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             count_clr;
    logic             detect;
    logic [PAT_W-1:0] pattern;
    logic             armed;
    logic [CNT_W-1:0] match_count;

    int n_tests = 0;
    int n_fail  = 0;

    seq_detect_param #(
        .PAT_W   (PAT_W),
        .PAT_RST (4'b1011),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .x           (x),
        .x_valid     (x_valid),
        .overlap     (overlap),
        .pat_load    (pat_load),
        .pat_in      (pat_in),
        .count_clr   (count_clr),
        .detect      (detect),
        .pattern     (pattern),
        .armed       (armed),
        .match_count (match_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input logic v, input logic b);
        x_valid = v;
        x       = b;
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        x       = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (detect !== 1'b0) begin
            $display("FAIL reset_detect: got %b want 0", detect); n_fail++;
        end
        n_tests++;
        if (armed !== 1'b0) begin
            $display("FAIL reset_armed: got %b want 0", armed); n_fail++;
        end
        n_tests++;
        if (pattern !== 4'b1011) begin
            $display("FAIL reset_pattern: got %b want 1011", pattern); n_fail++;
        end
        n_tests++;
        if (match_count !== 2'd0) begin
            $display("FAIL reset_count: got %0d want 0", match_count); n_fail++;
        end
    endtask

    task automatic run_stream(input string name, input logic ovl, input logic [6:0] bits,
                              input logic [6:0] exp);
        do_reset();
        overlap = ovl;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, bits[6-i]);
            n_tests++;
            if (detect !== exp[6-i]) begin
                $display("FAIL %s_detect bit %0d: got %b want %b", name, i + 1, detect, exp[6-i]);
                n_fail++;
            end
        end
        step(1'b0, 1'b0);
        n_tests++;
        if (detect !== 1'b0) begin
            $display("FAIL %s_pulse_width: got %b want 0", name, detect); n_fail++;
        end
    endtask

    task automatic test_overlap();
        run_stream("ovl", 1'b1, 7'b1011011, 7'b0001001);
        n_tests++;
        if (match_count !== CNT_W'(2 * CEN)) begin
            $display("FAIL ovl_count: got %0d want %0d", match_count, 2 * CEN); n_fail++;
        end
        n_tests++;
        if (armed !== 1'b1) begin
            $display("FAIL ovl_armed: got %b want 1", armed); n_fail++;
        end
    endtask

    task automatic test_non_overlap();
        run_stream("novl", 1'b0, 7'b1011011, 7'b0001000);
        n_tests++;
        if (match_count !== CNT_W'(CEN)) begin
            $display("FAIL novl_count: got %0d want %0d", match_count, CEN); n_fail++;
        end
        n_tests++;
        if (armed !== 1'b0) begin
            $display("FAIL novl_armed: got %b want 0", armed); n_fail++;
        end
    endtask

    task automatic test_valid_gap();
        logic [6:0] v;
        logic [6:0] b;
        logic [6:0] e;
        v = 7'b1100011;
        b = 7'b1011111;
        e = 7'b0000001;
        do_reset();
        overlap = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(v[6-i], b[6-i]);
            n_tests++;
            if (detect !== e[6-i]) begin
                $display("FAIL gap_detect cycle %0d: got %b want %b", i + 1, detect, e[6-i]);
                n_fail++;
            end
            if (i == 3) begin
                n_tests++;
                if (armed !== 1'b0) begin
                    $display("FAIL gap_armed_hold: got %b want 0", armed); n_fail++;
                end
            end
        end
        n_tests++;
        if (armed !== 1'b1) begin
            $display("FAIL gap_armed: got %b want 1", armed); n_fail++;
        end
    endtask

    task automatic test_pat_load();
        logic [3:0] b;
        logic [3:0] e;
        do_reset();
        overlap = 1'b1;
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        pat_load = 1'b1;
        pat_in   = 4'b1011;
        step(1'b1, 1'b1);
        pat_load = 1'b0;
        n_tests++;
        if (detect !== 1'b0) begin
            $display("FAIL load_suppress: got %b want 0", detect); n_fail++;
        end
        n_tests++;
        if (armed !== 1'b0) begin
            $display("FAIL load_armed: got %b want 0", armed); n_fail++;
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        n_tests++;
        if (detect !== 1'b0) begin
            $display("FAIL load_discard: got %b want 0", detect); n_fail++;
        end
        pat_load = 1'b1;
        pat_in   = 4'b0110;
        step(1'b1, 1'b0);
        pat_load = 1'b0;
        n_tests++;
        if (pattern !== 4'b0110) begin
            $display("FAIL load_pattern: got %b want 0110", pattern); n_fail++;
        end
        b = 4'b0110;
        e = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, b[3-i]);
            n_tests++;
            if (detect !== e[3-i]) begin
                $display("FAIL load_detect bit %0d: got %b want %b", i + 1, detect, e[3-i]);
                n_fail++;
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        rst       = 1'b1;
        pat_load  = 1'b1;
        pat_in    = 4'b0110;
        count_clr = 1'b0;
        step(1'b1, 1'b1);
        rst      = 1'b0;
        pat_load = 1'b0;
        n_tests++;
        if (pattern !== 4'b1011) begin
            $display("FAIL rstmid_pattern: got %b want 1011", pattern); n_fail++;
        end
        step(1'b1, 1'b1);
        n_tests++;
        if (detect !== 1'b0) begin
            $display("FAIL rstmid_detect: got %b want 0", detect); n_fail++;
        end
        n_tests++;
        if (armed !== 1'b0) begin
            $display("FAIL rstmid_armed: got %b want 0", armed); n_fail++;
        end
    endtask

    task automatic test_counter();
        do_reset();
        overlap = 1'b1;
        step(1'b1, 1'b1);
        for (int m = 1; m <= 5; m++) begin
            step(1'b1, 1'b0);
            step(1'b1, 1'b1);
            step(1'b1, 1'b1);
            n_tests++;
            if (detect !== 1'b1) begin
                $display("FAIL cnt_detect match %0d: got %b want 1", m, detect); n_fail++;
            end
            n_tests++;
            if (match_count !== CNT_W'(CEN * ((m > 3) ? 3 : m))) begin
                $display("FAIL cnt_sat match %0d: got %0d want %0d", m, match_count,
                         CEN * ((m > 3) ? 3 : m));
                n_fail++;
            end
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        count_clr = 1'b1;
        step(1'b1, 1'b1);
        count_clr = 1'b0;
        n_tests++;
        if (detect !== 1'b1) begin
            $display("FAIL clr_detect: got %b want 1", detect); n_fail++;
        end
        n_tests++;
        if (match_count !== 2'd0) begin
            $display("FAIL clr_count: got %0d want 0", match_count); n_fail++;
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        n_tests++;
        if (match_count !== CNT_W'(CEN)) begin
            $display("FAIL clr_recount: got %0d want %0d", match_count, CEN); n_fail++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        x         = 1'b0;
        x_valid   = 1'b0;
        overlap   = 1'b1;
        pat_load  = 1'b0;
        pat_in    = '0;
        count_clr = 1'b0;
        test_reset();
        test_overlap();
        test_non_overlap();
        test_valid_gap();
        test_pat_load();
        test_reset_mid();
        test_counter();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
